data_mem_responder: RTL and testbench

- Responder side of the CPU data-memory port: a word-addressed data store reached through a valid/ready request-response handshake.
- Each transaction costs a configurable number of cycles.
- Replaces the zero-latency combinational data memory when the CPU gains a stall-capable memory stage.
- Serves exactly one outstanding request at a time; writes are acknowledged with a response beat.

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/data_mem_responder_if.sv | 38 +++
 rtl/mem_word_array.sv | 36 +++
 rtl/data_mem_responder.sv | 111 +++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned ADDR_LSB      = 2;
   localparam int unsigned DEF_LATENCY   = 4;
   localparam int unsigned DEF_NUM_WORDS = 16384;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU memory stage (master) and the responder (slave).
// resp_err exists only when MEM_ALIGN_CHECK_EN is defined.
interface data_mem_responder_if;
   import mem_resp_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [WORD_W-1:0] resp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
`else
   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
`endif

endinterface

// File: rtl/mem_word_array.sv
// NUM_WORDS x 32 word store: synchronous write, registered read.
// A store access clears the read register so store acknowledgements return 0.
module mem_word_array
   import mem_resp_pkg::*;
#(
   parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         we,
   input  logic                         clr,
   input  logic [$clog2(NUM_WORDS)-1:0] idx,
   input  logic [WORD_W-1:0]            wdata,
   output logic [WORD_W-1:0]            rdata
);

   logic [WORD_W-1:0] mem [NUM_WORDS];

   // Storage write; contents survive reset, and reset blocks a coinciding write.
   always_ff @(posedge clk) begin
      if (en && we && !reset) begin
         mem[idx] <= wdata;
      end
   end

   // Read register: load data, zero for store acks and rejected accesses.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= we ? '0 : mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding request, fixed LATENCY cycles to response.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned addresses with resp_err.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
   parameter int unsigned LATENCY   = DEF_LATENCY
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus,
   output logic                 busy
);

   localparam int unsigned IDX_W = $clog2(NUM_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_write;
   logic [IDX_W-1:0]  lat_idx;
   logic [WORD_W-1:0] lat_wdata;
   logic              access_c;
   logic              mem_en;
   logic              mem_clr;
   logic              unused_addr;

   // Only the word-index bits (and low bits when checked) matter.
   assign unused_addr = ^bus.req_addr;

   assign bus.req_ready = (state == IDLE) && !reset;
   assign access_c      = (state == WAIT) && (cnt == '0) && !reset;

`ifdef MEM_ALIGN_CHECK_EN
   logic lat_misaligned;

   assign mem_en  = access_c && !lat_misaligned;
   assign mem_clr = access_c && lat_misaligned;
`else
   assign mem_en  = access_c;
   assign mem_clr = 1'b0;
`endif

   // Handshake FSM with latency counter; all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         busy           <= 1'b0;
         bus.resp_valid <= 1'b0;
         lat_write      <= 1'b0;
         lat_idx        <= '0;
         lat_wdata      <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         lat_misaligned <= 1'b0;
         bus.resp_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_write <= bus.req_write;
                  lat_idx   <= bus.req_addr[ADDR_LSB +: IDX_W];
                  lat_wdata <= bus.req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
                  lat_misaligned <= |bus.req_addr[ADDR_LSB-1:0];
`endif
                  cnt   <= CNT_W'(LATENCY - 1);
                  busy  <= 1'b1;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  bus.resp_valid <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                  bus.resp_err   <= lat_misaligned;
`endif
                  state <= RESP;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   mem_word_array #(
      .NUM_WORDS (NUM_WORDS)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .en    (mem_en),
      .we    (lat_write),
      .clr   (mem_clr),
      .idx   (lat_idx),
      .wdata (lat_wdata),
      .rdata (bus.resp_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level model checked every cycle on the
// LATENCY=4 instance, plus directed literal checks on it and on a LATENCY=1 instance.
module tb_data_mem_responder;

   localparam int unsigned LAT0 = 4;
   localparam int unsigned NW0  = 16384;
   localparam int unsigned LAT1 = 1;
   localparam int unsigned NW1  = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req_valid, req_write, resp_ready, sel1;
   logic [31:0] req_addr, req_wdata;
   logic        busy0, busy1;

   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();

   assign bus0.req_valid  = req_valid & ~sel1;
   assign bus1.req_valid  = req_valid & sel1;
   assign bus0.req_write  = req_write;
   assign bus1.req_write  = req_write;
   assign bus0.req_addr   = req_addr;
   assign bus1.req_addr   = req_addr;
   assign bus0.req_wdata  = req_wdata;
   assign bus1.req_wdata  = req_wdata;
   assign bus0.resp_ready = resp_ready;
   assign bus1.resp_ready = resp_ready;

   data_mem_responder #(.NUM_WORDS(NW0), .LATENCY(LAT0)) u_dut0 (
      .clk (clk), .reset (reset), .bus (bus0), .busy (busy0)
   );

   data_mem_responder #(.NUM_WORDS(NW1), .LATENCY(LAT1)) u_dut1 (
      .clk (clk), .reset (reset), .bus (bus1), .busy (busy1)
   );

   int unsigned nvec  = 0;
   int unsigned nfail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model of the LATENCY=4 instance.
   longint      cyc = 0;
   bit          chk_en = 1'b0;
   bit          m_out = 1'b0;
   longint      m_acc = 0;
   bit          m_wr, m_mis;
   int unsigned m_idx;
   logic [31:0] m_wd;
   logic [31:0] m_rdata = '0;
   bit          m_err = 1'b0;
   logic [31:0] m_mem [int unsigned];

   always @(posedge clk) begin
      if (reset) begin
         m_out   = 1'b0;
         m_rdata = '0;
         m_err   = 1'b0;
      end else if (m_out) begin
         if (cyc + 1 == m_acc + LAT0) begin
            m_err = m_mis;
            if (m_mis) begin
               m_rdata = '0;
            end else if (m_wr) begin
               m_mem[m_idx] = m_wd;
               m_rdata      = '0;
            end else begin
               m_rdata = m_mem.exists(m_idx) ? m_mem[m_idx] : 32'h0;
            end
         end else if (cyc >= m_acc + LAT0 && resp_ready) begin
            m_out = 1'b0;
         end
      end else if (req_valid && !sel1) begin
         m_out = 1'b1;
         m_acc = cyc + 1;
         m_wr  = req_write;
         m_idx = (req_addr >> 2) % NW0;
         m_wd  = req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
         m_mis = (req_addr[1:0] != 2'b00);
`else
         m_mis = 1'b0;
`endif
      end
      cyc    = cyc + 1;
      chk_en = 1'b1;
   end

   // Per-cycle compare of instance 0 outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 32'(bus0.req_ready), 32'(!m_out && !reset));
         check("resp_valid", 32'(bus0.resp_valid), 32'(m_out && (cyc >= m_acc + LAT0)));
         check("busy", 32'(busy0), 32'(m_out));
         check("resp_rdata", bus0.resp_rdata, m_rdata);
`ifdef MEM_ALIGN_CHECK_EN
         check("resp_err", 32'(bus0.resp_err), 32'(m_err));
`endif
      end
   end

   // One transaction; called at posedge+1 with the selected instance idle.
   task automatic txn(input bit s1, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] rd, output int lat);
      sel1 = s1; req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!(s1 ? bus1.resp_valid : bus0.resp_valid) && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 50) begin
         nvec++; nfail++;
         $display("FAIL timeout: no resp_valid within 50 cycles, addr %h", a);
      end
      rd = s1 ? bus1.resp_rdata : bus0.resp_rdata;
      if (hold > 0) begin
         // Competing request while the response is held back.
         req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_wdata = 32'hBAD0BAD0;
         repeat (hold) begin @(posedge clk); #1; end
         req_valid = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   int          lat;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0; sel1 = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("idle req_ready", 32'(bus0.req_ready), 32'h1);
      check("idle rdata", bus0.resp_rdata, 32'h0);

      txn(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 0, rd, lat);
      check("store latency", 32'(lat), 32'd4);
      check("store ack rdata", rd, 32'h0);
      txn(1'b0, 1'b0, 32'h100, 32'h0, 0, rd, lat);
      check("load latency", 32'(lat), 32'd4);
      check("load rdata", rd, 32'hDEADBEEF);

      txn(1'b0, 1'b0, 32'h100, 32'h0, 10, rd, lat);
      check("backpressure rdata", rd, 32'hDEADBEEF);
      txn(1'b0, 1'b0, 32'h100, 32'h0, 0, rd, lat);
      check("ignored request no write", rd, 32'hDEADBEEF);

      txn(1'b0, 1'b1, NW0 * 4 + 32'h8, 32'h12345678, 0, rd, lat);
      txn(1'b0, 1'b0, 32'h8, 32'h0, 0, rd, lat);
      check("wrap load", rd, 32'h12345678);

      txn(1'b0, 1'b0, 32'h102, 32'h0, 0, rd, lat);
`ifdef MEM_ALIGN_CHECK_EN
      check("misaligned rdata", rd, 32'h0);
      check("misaligned latency", 32'(lat), 32'd4);
      check("misaligned err", 32'(bus0.resp_err), 32'h1);
      txn(1'b0, 1'b0, 32'h100, 32'h0, 0, rd, lat);
      check("aligned err", 32'(bus0.resp_err), 32'h0);
      check("aligned rdata", rd, 32'hDEADBEEF);
`else
      check("low bits ignored", rd, 32'hDEADBEEF);
`endif

      // Reset while a store waits.
      txn(1'b0, 1'b1, 32'h20, 32'h11111111, 0, rd, lat);
      sel1 = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("busy after reset", 32'(busy0), 32'h0);
      check("resp_valid after reset", 32'(bus0.resp_valid), 32'h0);
      txn(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, lat);
      check("store dropped by reset", rd, 32'h11111111);

      // Reset on the very write edge.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5A5A5A5A;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      txn(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, lat);
      check("write edge reset priority", rd, 32'h11111111);

      // LATENCY=1 instance, 64 words.
      txn(1'b1, 1'b1, NW1 * 4 + 32'h8, 32'h12345678, 0, rd, lat);
      check("lat1 store latency", 32'(lat), 32'd1);
      check("lat1 store ack", rd, 32'h0);
      txn(1'b1, 1'b0, 32'h8, 32'h0, 0, rd, lat);
      check("lat1 load latency", 32'(lat), 32'd1);
      check("lat1 wrap load", rd, 32'h12345678);
      txn(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, 0, rd, lat);
      txn(1'b1, 1'b0, 32'h104, 32'h0, 0, rd, lat);
      check("lat1 wrap alias", rd, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
